// File: rtl/rader7_pkg.sv
// rader7_pkg: shared types, index tables and twiddle helper for rader7_stream.
// Twiddles are derived from Q16 cos/sin values, rounded to CW bits.
package rader7_pkg;

  typedef enum logic [1:0] {
    LOAD,
    RUN,
    OUT
  } state_t;

  localparam int N          = 7;
  localparam int RUN_CYCLES = 15;

  localparam logic [2:0] PERM [6] = '{3'd5, 3'd4, 3'd6, 3'd2, 3'd3, 3'd1};

  // Bin produced on each of the six convolution outputs
  localparam logic [2:0] BIN [6] = '{3'd1, 3'd3, 3'd2, 3'd6, 3'd4, 3'd5};

  // Twiddle index for FIR tap d: 3^(d-1) mod 7
  localparam int HM [6] = '{5, 1, 3, 2, 6, 4};

  localparam int COS_Q16 [4] = '{65536, 40861, -14583, -59046};
  localparam int SIN_Q16 [4] = '{0, 51238, 63893, 28435};

  function automatic int twiddle(int m, int cw, bit s);
    int     k;
    longint v;
    k = (m > 3) ? N - m : m;
    v = s ? longint'(SIN_Q16[k]) : longint'(COS_Q16[k]);
    if (s && m > 3) v = -v;
    return int'((v * (longint'(1) << (cw - 1)) + 32768) >>> 16);
  endfunction

endpackage

// File: rtl/rader7_fir.sv
// rader7_fir: 6-tap transposed-form FIR with an int coefficient vector.
// Delay registers carry no reset; outputs are only used once fully primed.
module rader7_fir
  import rader7_pkg::*;
#(
  parameter int W  = 8,
  parameter int AW = 20,
  parameter int H [6] = '{default: 0}
) (
  input  logic                 clk,
  input  logic signed [W-1:0]  x,
  output logic signed [AW-1:0] y
);

  logic signed [AW-1:0] p [6];
  logic signed [AW-1:0] r [5];

  always_comb begin
    for (int i = 0; i < 6; i++) begin
      p[i] = AW'(x) * AW'(H[i]);
    end
  end

  assign y = p[0] + r[0];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      r[i] <= p[i+1] + r[i+1];
    end
    r[4] <= p[5];
  end

endmodule

// File: rtl/rader7_stream.sv
// rader7_stream: streaming 7-point real-input DFT using Rader's algorithm.
// Define RADER7_STREAM_ROUND_EN for round-half-up on bins 1..6.
module rader7_stream
  import rader7_pkg::*;
#(
  parameter int W  = 8,
  parameter int CW = 9
) (
  input  logic                clk,
  input  logic                reset,
  input  logic signed [W-1:0] x_in,
  input  logic                x_valid,
  output logic                x_ready,
  input  logic                inv,
  output logic signed [W+2:0] y_real,
  output logic signed [W+2:0] y_imag,
  output logic [2:0]          y_idx,
  output logic                y_valid,
  input  logic                y_ready
);

  localparam int AW = W + CW + 3;
  localparam int OW = W + 3;

  localparam int HC [6] = '{
    twiddle(HM[0], CW, 1'b0), twiddle(HM[1], CW, 1'b0),
    twiddle(HM[2], CW, 1'b0), twiddle(HM[3], CW, 1'b0),
    twiddle(HM[4], CW, 1'b0), twiddle(HM[5], CW, 1'b0)
  };
  localparam int HS [6] = '{
    twiddle(HM[0], CW, 1'b1), twiddle(HM[1], CW, 1'b1),
    twiddle(HM[2], CW, 1'b1), twiddle(HM[3], CW, 1'b1),
    twiddle(HM[4], CW, 1'b1), twiddle(HM[5], CW, 1'b1)
  };

`ifdef RADER7_STREAM_ROUND_EN
  localparam logic signed [AW-1:0] RND = AW'(2 ** (CW - 2));
`else
  localparam logic signed [AW-1:0] RND = '0;
`endif

  state_t               state;
  logic [2:0]           lidx;
  logic [3:0]           cnt;
  logic                 inv_q;
  logic signed [W-1:0]  xbuf [N];
  logic signed [OW-1:0] res_re [1:6];
  logic signed [OW-1:0] res_im [1:6];

  logic [2:0]           fidx;
  logic [2:0]           bin_at;
  logic signed [W-1:0]  feed;
  logic signed [AW-1:0] re_sum;
  logic signed [AW-1:0] im_sum;
  logic signed [AW-1:0] im_term;
  logic signed [AW-1:0] re_sh;
  logic signed [AW-1:0] im_sh;
  logic signed [OW-1:0] x0_sum;
  logic signed [OW-1:0] bin_re;
  logic signed [OW-1:0] bin_im;
  logic                 cap;

  // Feed a[1..5], a[0], a[1..5] so cycles 5..10 hold the cyclic outputs
  always_comb begin
    fidx = 3'd0;
    if (cnt <= 4'd4) fidx = 3'(cnt + 4'd1);
    else if (cnt <= 4'd10) fidx = 3'(cnt - 4'd5);
    bin_at = BIN[3'(cnt - 4'd5)];
    cap    = (state == RUN) && (cnt >= 4'd5) && (cnt <= 4'd10);
  end

  assign feed = xbuf[PERM[fidx]];

  rader7_fir #(.W(W), .AW(AW), .H(HC)) u_cos (
    .clk (clk),
    .x   (feed),
    .y   (re_sum)
  );

  rader7_fir #(.W(W), .AW(AW), .H(HS)) u_sin (
    .clk (clk),
    .x   (feed),
    .y   (im_sum)
  );

  assign im_term = inv_q ? im_sum : -im_sum;
  assign re_sh   = (re_sum + RND) >>> (CW - 1);
  assign im_sh   = (im_term + RND) >>> (CW - 1);
  assign bin_re  = OW'(re_sh) + OW'(xbuf[0]);
  assign bin_im  = OW'(im_sh);

  always_comb begin
    x0_sum = '0;
    for (int i = 0; i < N; i++) begin
      x0_sum = x0_sum + OW'(xbuf[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && state == LOAD && x_valid) begin
      xbuf[lidx] <= x_in;
      if (lidx == 3'd0) inv_q <= inv;
    end
    if (cap) begin
      res_re[bin_at] <= bin_re;
      res_im[bin_at] <= bin_im;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= LOAD;
      lidx    <= 3'd0;
      cnt     <= 4'd0;
      x_ready <= 1'b1;
      y_valid <= 1'b0;
      y_real  <= '0;
      y_imag  <= '0;
      y_idx   <= 3'd0;
    end else begin
      unique case (state)
        LOAD: begin
          if (x_valid) begin
            if (lidx == 3'd6) begin
              state   <= RUN;
              lidx    <= 3'd0;
              cnt     <= 4'd0;
              x_ready <= 1'b0;
            end else begin
              lidx <= lidx + 3'd1;
            end
          end
        end
        RUN: begin
          cnt <= cnt + 4'd1;
          if (cnt == 4'(RUN_CYCLES)) begin
            state   <= OUT;
            y_valid <= 1'b1;
            y_idx   <= 3'd0;
            y_real  <= x0_sum;
            y_imag  <= '0;
          end
        end
        OUT: begin
          if (y_ready) begin
            if (y_idx == 3'd6) begin
              state   <= LOAD;
              y_valid <= 1'b0;
              x_ready <= 1'b1;
            end else begin
              y_idx  <= y_idx + 3'd1;
              y_real <= res_re[y_idx + 3'd1];
              y_imag <= res_im[y_idx + 3'd1];
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_rader7_stream.sv
// tb_rader7_stream: directed frames with hand-computed DFT bins.
// Covers reset, latency, backpressure, inverse, mid-RUN reset.
module tb_rader7_stream;

  logic               clk = 1'b0;
  logic               reset;
  logic signed [7:0]  x_in;
  logic               x_valid;
  logic               x_ready;
  logic               inv;
  logic signed [10:0] y_real;
  logic signed [10:0] y_imag;
  logic [2:0]         y_idx;
  logic               y_valid;
  logic               y_ready;

  int n_checks = 0;
  int n_fail   = 0;
  int xv [7];
  int er [7];
  int ei [7];

  always #5 clk = ~clk;

  rader7_stream #(.W(8), .CW(9)) dut (
    .clk     (clk),
    .reset   (reset),
    .x_in    (x_in),
    .x_valid (x_valid),
    .x_ready (x_ready),
    .inv     (inv),
    .y_real  (y_real),
    .y_imag  (y_imag),
    .y_idx   (y_idx),
    .y_valid (y_valid),
    .y_ready (y_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input int expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // inv is flipped after x[0] to show it is only sampled with x[0]
  task automatic send_frame(input string tag, input logic iv);
    for (int i = 0; i < 7; i++) begin
      int g;
      g = 0;
      while (!x_ready && g < 50) begin
        tick();
        g++;
      end
      chk($sformatf("%s_xready%0d", tag, i), x_ready, 1);
      x_in    = 8'(xv[i]);
      x_valid = 1'b1;
      inv     = (i == 0) ? iv : ~iv;
      tick();
    end
    x_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int c;
    c = 0;
    while (!y_valid && c < 40) begin
      tick();
      c++;
    end
    chk({tag, "_latency"}, c, 16);
    chk({tag, "_xready_out"}, x_ready, 0);
  endtask

  task automatic recv(input string tag, input int hold_at);
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("%s_valid%0d", tag, k), y_valid, 1);
      chk($sformatf("%s_idx%0d", tag, k), y_idx, k);
      chk($sformatf("%s_re%0d", tag, k), y_real, er[k]);
      chk($sformatf("%s_im%0d", tag, k), y_imag, ei[k]);
      if (k == hold_at) begin
        y_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
          tick();
          chk($sformatf("%s_hold_re%0d", tag, j), y_real, er[k]);
          chk($sformatf("%s_hold_im%0d", tag, j), y_imag, ei[k]);
          chk($sformatf("%s_hold_idx%0d", tag, j), y_idx, k);
          chk($sformatf("%s_hold_xr%0d", tag, j), x_ready, 0);
        end
        y_ready = 1'b1;
      end
      tick();
    end
    chk({tag, "_xready_after"}, x_ready, 1);
    chk({tag, "_valid_after"}, y_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    x_in    = '0;
    x_valid = 1'b0;
    inv     = 1'b0;
    y_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_xready", x_ready, 1);
    chk("rst_yvalid", y_valid, 0);
    chk("rst_re", y_real, 0);
    chk("rst_im", y_imag, 0);
    chk("rst_idx", y_idx, 0);

    // Impulse at x[0], with a 5-cycle stall at bin 3
    xv = '{100, 0, 0, 0, 0, 0, 0};
    er = '{100, 100, 100, 100, 100, 100, 100};
    ei = '{0, 0, 0, 0, 0, 0, 0};
    send_frame("imp", 1'b0);
    wait_out("imp");
    recv("imp", 3);

    // DC, issued back to back
    xv = '{10, 10, 10, 10, 10, 10, 10};
    er = '{70, 0, 0, 0, 0, 0, 0};
    ei = '{0, 0, 0, 0, 0, 0, 0};
    send_frame("dc", 1'b0);
    wait_out("dc");
    recv("dc", -1);

    // x[1]=100 forward, with junk x_valid beats during RUN
    xv = '{0, 100, 0, 0, 0, 0, 0};
`ifdef RADER7_STREAM_ROUND_EN
    er = '{100, 63, -22, -90, -90, -22, 63};
    ei = '{0, -78, -98, -43, 43, 98, 78};
`else
    er = '{100, 62, -23, -91, -91, -23, 62};
    ei = '{0, -79, -98, -44, 43, 97, 78};
`endif
    send_frame("x1f", 1'b0);
    x_valid = 1'b1;
    x_in    = 8'sd127;
    wait_out("x1f");
    x_valid = 1'b0;
    recv("x1f", -1);

    // x[1]=100 inverse
`ifdef RADER7_STREAM_ROUND_EN
    ei = '{0, 78, 98, 43, -43, -98, -78};
`else
    ei = '{0, 78, 97, 43, -44, -98, -79};
`endif
    send_frame("x1i", 1'b1);
    wait_out("x1i");
    recv("x1i", -1);

    // Negative sample at x[3]
    xv = '{0, 0, 0, -50, 0, 0, 0};
`ifdef RADER7_STREAM_ROUND_EN
    er = '{-50, 45, -31, 11, 11, -31, 45};
    ei = '{0, 22, -39, 49, -49, 39, -22};
`else
    er = '{-50, 45, -32, 11, 11, -32, 45};
    ei = '{0, 21, -40, 48, -49, 39, -22};
`endif
    send_frame("x3", 1'b0);
    wait_out("x3");
    recv("x3", -1);

    // Reset at RUN cycle 7 drops the frame
    xv = '{0, 100, 0, 0, 0, 0, 0};
    send_frame("rr", 1'b0);
    for (int i = 0; i < 7; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rr_xready", x_ready, 1);
    chk("rr_yvalid", y_valid, 0);
    chk("rr_re", y_real, 0);
    chk("rr_idx", y_idx, 0);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 30; i++) begin
        if (y_valid) seen++;
        tick();
      end
      chk("rr_no_valid", seen, 0);
    end

    // Fresh frame after the reset
    xv = '{10, 10, 10, 10, 10, 10, 10};
    er = '{70, 0, 0, 0, 0, 0, 0};
    ei = '{0, 0, 0, 0, 0, 0, 0};
    send_frame("post", 1'b0);
    wait_out("post");
    recv("post", -1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
